// File: rtl/gray_decode_arbiter.sv
// Round-robin arbiter sharing one Gray-to-binary decoder among R requesters.
// A captured Gray word is decoded and returned on a valid/ready port, tagged with its requester index.
module gray_decode_arbiter #(
  parameter  int N    = 4,
  parameter  int R    = 4,
  localparam int ID_W = (R > 1) ? $clog2(R) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [R-1:0]    req,
  input  logic [R*N-1:0]  gray_in,
  output logic [R-1:0]    ack,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_bin,
  output logic [ID_W-1:0] out_id,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, CONVERT, OUT} state_t;

  state_t          state;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] id_reg;
  logic [N-1:0]    gray_reg;

  logic [ID_W-1:0] winner;
  logic [N-1:0]    gray_sel;
  logic [N-1:0]    dec;
  logic            found;
  int              idx;

  // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    winner   = '0;
    gray_sel = '0;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < R; i++) begin
      idx = (int'(ptr) + i) % R;
      if (!found && req[idx]) begin
        found    = 1'b1;
        winner   = ID_W'(idx);
        gray_sel = gray_in[idx*N +: N];
      end
    end
  end

  // Single shared decoder: bit i is the XOR of all Gray bits from i upward.
  always_comb begin
    dec = '0;
    for (int i = 0; i < N; i++) begin
      dec[i] = ^(gray_reg >> i);
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      id_reg    <= '0;
      gray_reg  <= '0;
      ack       <= '0;
      out_valid <= 1'b0;
      out_bin   <= '0;
      out_id    <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            gray_reg <= gray_sel;
            id_reg   <= winner;
            ack      <= R'(1) << winner;
            busy     <= 1'b1;
            state    <= CONVERT;
          end
        end
        CONVERT: begin
          ack       <= '0;
          out_bin   <= dec;
          out_id    <= id_reg;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            ptr       <= (out_id == ID_W'(R - 1)) ? '0 : out_id + 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          ack       <= '0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gray_decode_arbiter.sv
// Directed bench for gray_decode_arbiter: expected results are queued when a request
// is driven and compared when the matching result appears on the output port.
module tb_gray_decode_arbiter;

  localparam int N = 4;
  localparam int R = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [R-1:0]  req;
  logic [R*N-1:0] gray_in;
  logic [R-1:0]  ack;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_bin;
  logic [1:0]    out_id;
  logic          busy;

  gray_decode_arbiter #(.N(N), .R(R)) dut (
    .clk(clk), .rst(rst), .req(req), .gray_in(gray_in), .ack(ack),
    .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin),
    .out_id(out_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] id;
    logic [3:0] bin;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;

  function automatic logic [3:0] g2b(input logic [3:0] g);
    return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  task automatic push(input logic [1:0] id, input logic [3:0] bin);
    exp_t e;
    e.id  = id;
    e.bin = bin;
    sb.push_back(e);
  endtask

  task automatic pop(input string tag, output exp_t e);
    if (sb.size() == 0) begin
      $display("FAIL %s: scoreboard empty", tag);
      $fatal(1, "scoreboard underflow");
    end
    e = sb.pop_front();
  endtask

  // One full transaction with out_ready high: CONVERT, OUT, then back in IDLE.
  task automatic run_txn(input string tag);
    exp_t e;
    pop(tag, e);
    step();
    check({tag, ".ack"}, 32'(ack), 32'(4'b0001 << e.id));
    check({tag, ".busy_conv"}, 32'(busy), 32'd1);
    check({tag, ".valid_conv"}, 32'(out_valid), 32'd0);
    step();
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".id"}, 32'(out_id), 32'(e.id));
    check({tag, ".bin"}, 32'(out_bin), 32'(e.bin));
    check({tag, ".ack_out"}, 32'(ack), 32'd0);
    step();
    check({tag, ".valid_idle"}, 32'(out_valid), 32'd0);
    check({tag, ".busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [3:0] gv [4];
    logic [3:0] spot_g [3];
    logic [3:0] spot_b [3];
    exp_t e;

    gv[0] = 4'hB; gv[1] = 4'h6; gv[2] = 4'h3; gv[3] = 4'hD;
    spot_g[0] = 4'b1000; spot_b[0] = 4'b1111;
    spot_g[1] = 4'b0110; spot_b[1] = 4'b0100;
    spot_g[2] = 4'b1111; spot_b[2] = 4'b1010;

    // Reset held two cycles while every requester is asking.
    rst       = 1'b1;
    req       = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < R; k++) gray_in[k*N +: N] = gv[k];
    step();
    step();
    check("rst.ack", 32'(ack), 32'd0);
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.bin", 32'(out_bin), 32'd0);
    check("rst.id", 32'(out_id), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);

    // Fairness: all requesting, grants rotate 0,1,2,3,0,1 every three cycles.
    rst = 1'b0;
    for (int n = 0; n < 6; n++) push(2'(n % 4), g2b(gv[n % 4]));
    for (int n = 0; n < 6; n++) run_txn($sformatf("fair%0d", n));

    // Single request from requester 0.
    req = 4'b0001;
    gray_in[3:0] = 4'b1101;
    push(2'd0, 4'b1001);
    run_txn("single");

    // Backpressure: result held while out_ready is low.
    req = 4'b0110;
    gray_in[7:4]  = 4'b0110;
    gray_in[11:8] = 4'b1011;
    out_ready = 1'b0;
    push(2'd1, g2b(4'b0110));
    pop("bp", e);
    step();
    check("bp.ack", 32'(ack), 32'b0010);
    step();
    check("bp.valid", 32'(out_valid), 32'd1);
    check("bp.id", 32'(out_id), 32'(e.id));
    check("bp.bin", 32'(out_bin), 32'(e.bin));
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("bp.hold%0d.valid", c), 32'(out_valid), 32'd1);
      check($sformatf("bp.hold%0d.id", c), 32'(out_id), 32'(e.id));
      check($sformatf("bp.hold%0d.bin", c), 32'(out_bin), 32'(e.bin));
      check($sformatf("bp.hold%0d.ack", c), 32'(ack), 32'd0);
    end
    out_ready = 1'b1;
    step();
    check("bp.release", 32'(out_valid), 32'd0);
    push(2'd2, g2b(4'b1011));
    run_txn("bp.next");

    // Every Gray code through requester 2, then fixed spot values.
    req = 4'b0100;
    for (int g = 0; g < 16; g++) begin
      gray_in[11:8] = 4'(g);
      push(2'd2, g2b(4'(g)));
      run_txn($sformatf("exh%0d", g));
    end
    for (int s = 0; s < 3; s++) begin
      gray_in[11:8] = spot_g[s];
      push(2'd2, spot_b[s]);
      run_txn($sformatf("spot%0d", s));
    end

    // Reset while a result is pending in OUT (ptr is 3 here).
    req = 4'b0001;
    gray_in[3:0] = 4'b0101;
    out_ready = 1'b0;
    step();
    step();
    check("mid.valid_before", 32'(out_valid), 32'd1);
    rst = 1'b1;
    step();
    check("mid.valid", 32'(out_valid), 32'd0);
    check("mid.busy", 32'(busy), 32'd0);
    check("mid.ack", 32'(ack), 32'd0);
    check("mid.bin", 32'(out_bin), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    req = 4'b1010;
    gray_in[7:4]   = 4'b0011;
    gray_in[15:12] = 4'b1110;
    push(2'd1, g2b(4'b0011));
    run_txn("post_rst");

    req = 4'b0000;
    step();
    check("end.sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/gray_decode_arbiter.md
# gray_decode_arbiter

Round-robin arbiter and sequencer that shares one combinational N-bit Gray-to-binary decoder among R requesters. It accepts one Gray word at a time through a req/ack handshake, registers the word in front of the shared decoder, and registers the decoded binary result. The result is presented on a valid/ready output port tagged with the requester index. It sits between several Gray-coded sources (counters, pointers, encoders) and a single consumer of binary values.

## Interface
- N, 4, data width in bits (N ≥ 2)
- R, 4, number of requesters (2..8); ID_W = $clog2(R)
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- req  input  R  per-requester request; each requester holds its bit until it sees its ack bit
- gray_in  input  R*N  packed Gray words; requester k uses bits [k*N +: N]
- ack  output  R  one-hot, one-cycle pulse meaning the requester's word was captured
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts the result
- out_bin  output  N  decoded binary value
- out_id  output  ID_W  index of the requester that owns out_bin
- busy  output  1  high whenever the state is not IDLE

## Operation
- Shared decoder: bin[N-1] = gray[N-1]; bin[i] = bin[i+1] ^ gray[i]. There is exactly one decoder instance, fed from gray_reg.
- Round-robin pointer ptr (ID_W bits, reset 0):
  - The winner is the first set req bit, searching ptr, ptr+1, … modulo R.
  - After an output handshake, ptr ← (out_id + 1) mod R.
- FSM states: IDLE, CONVERT, OUT.
  - IDLE: if req ≠ 0, capture gray_reg ← gray_in[winner] and id_reg ← winner, then go to CONVERT. Otherwise stay in IDLE. A requester may drop req while in IDLE without being granted.
  - CONVERT: ack[id_reg] = 1 for this cycle only. Capture out_bin ← decoder(gray_reg) and out_id ← id_reg, then go to OUT. req is ignored.
  - OUT: out_valid = 1. When out_valid && out_ready, update ptr and go to IDLE. Otherwise hold, with out_bin and out_id stable. req is ignored.
- A captured transaction always completes. Dropping req after capture has no effect.
- A requester that keeps req high after its ack is treated as a new request in the next IDLE cycle, subject to round-robin order.
- No output queuing: a new grant happens only after the previous result is accepted.
- Reset from any state:
  - state goes to IDLE and ptr to 0.
  - ack, out_valid, out_bin, out_id, busy and gray_reg all go to 0.
  - Any in-flight result is discarded and no ack is issued for it.

## Timing
- Edge T0: requests are sampled in IDLE.
- Cycle T0+1: CONVERT, with the ack pulse.
- Cycle T0+2: out_valid = 1.
- Minimum latency from req to out_valid is 2 cycles.
- Minimum period between grants is 3 cycles, reached when out_ready = 1 throughout.
- If out_ready is high in the first OUT cycle, the handshake completes in that cycle and IDLE is the following cycle.
- All outputs are registered. ack is a registered decode of state == CONVERT and id_reg.
- There is no combinational path from req or out_ready to any output.
- busy = 1 in CONVERT and OUT.

## Test plan
1. Reset: drive rst = 1 for 2 cycles with req = 4'b1111 → ack = 0, out_valid = 0, out_bin = 0, out_id = 0, busy = 0. The first grant after release goes to requester 0.
2. Single request: req = 4'b0001, gray_in[3:0] = 4'b1101, out_ready = 1 → ack = 4'b0001 at T0+1; out_valid = 1 with out_bin = 4'b1001 and out_id = 0 at T0+2; IDLE at T0+3.
3. Fairness: req = 4'b1111 held continuously, each requester k with a distinct Gray value, out_ready = 1 → out_id sequence 0, 1, 2, 3, 0, 1, with a grant every 3 cycles and each out_bin correctly decoded.
4. Backpressure: result pending with out_ready = 0 for 5 cycles while req = 4'b0110 → out_valid stays 1, out_bin and out_id stay stable, and ack stays 0. After out_ready = 1, the next grant follows ptr order.
5. Exhaustive decode: for gray_in[11:8] = 0..15 through requester 2 → out_bin equals Gray⁻¹. Spot checks: 4'b1000 → 4'b1111, 4'b0110 → 4'b0100, 4'b1111 → 4'b1010.
6. Reset mid-operation: assert rst in OUT with ptr = 3 → out_valid = 0 on the next cycle and the result is lost. After release with req = 4'b1010, requester 1 is granted first (ptr = 0).
